// File: rtl/fifo_no_space_tracker.sv
// Single-clock FIFO that flags writes attempted while full, pulses once per
// error episode and keeps a saturating, software-clearable episode count.
module fifo_no_space_tracker #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              no_space_err,
   output logic              no_space_ctr_incr,
   output logic [CNT_W-1:0]  no_space_cnt,
   output logic              cnt_sat,
   input  logic              cnt_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              accept;
   logic              rd_ok;
   logic              err_d;
   logic [CNT_W-1:0]  cnt_nxt;

   assign full   = (count == FULL_LVL);
   assign empty  = (count == '0);
   // A same-cycle read never frees space for the write: full is pre-edge state.
   assign accept = wr_en & ~full;
   assign rd_ok  = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_ONE;
         end
         rd_valid <= rd_ok;
         case ({accept, rd_ok})
            2'b10:   count <= count + OCC_ONE;
            2'b01:   count <= count - OCC_ONE;
            default: count <= count;
         endcase
      end
   end

   // Clear wins over a coincident increment; the increment is dropped.
   always_comb begin
      cnt_nxt = no_space_cnt;
      if (cnt_clr)
         cnt_nxt = '0;
      else if (no_space_ctr_incr && !cnt_sat)
         cnt_nxt = no_space_cnt + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         no_space_err      <= 1'b0;
         err_d             <= 1'b0;
         no_space_ctr_incr <= 1'b0;
         no_space_cnt      <= '0;
         cnt_sat           <= 1'b0;
      end else begin
         no_space_err      <= wr_en & full;
         err_d             <= no_space_err;
         no_space_ctr_incr <= no_space_err & ~err_d;
         no_space_cnt      <= cnt_nxt;
         cnt_sat           <= &cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_no_space_tracker.sv
// Directed bench for fifo_no_space_tracker: FIFO ordering, no-space episodes,
// counter saturation/clear and asynchronous reset.
module tb_fifo_no_space_tracker;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       no_space_err;
   logic       no_space_ctr_incr;
   logic [1:0] no_space_cnt;
   logic       cnt_sat;
   logic       cnt_clr;

   int checks = 0;
   int errors = 0;

   fifo_no_space_tracker #(.DATA_W(8), .DEPTH(4), .CNT_W(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .wr_en             (wr_en),
      .wr_data           (wr_data),
      .rd_en             (rd_en),
      .rd_data           (rd_data),
      .rd_valid          (rd_valid),
      .full              (full),
      .empty             (empty),
      .no_space_err      (no_space_err),
      .no_space_ctr_incr (no_space_ctr_incr),
      .no_space_cnt      (no_space_cnt),
      .cnt_sat           (cnt_sat),
      .cnt_clr           (cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic episode(input logic [1:0] exp_cnt, input logic exp_sat);
      wr_en = 1'b1;
      tick();
      chk("ep_err", {31'd0, no_space_err}, 32'd1);
      wr_en = 1'b0;
      tick();
      chk("ep_incr", {31'd0, no_space_ctr_incr}, 32'd1);
      tick();
      chk("ep_incr_off", {31'd0, no_space_ctr_incr}, 32'd0);
      chk("ep_cnt", {30'd0, no_space_cnt}, {30'd0, exp_cnt});
      chk("ep_sat", {31'd0, cnt_sat}, {31'd0, exp_sat});
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; cnt_clr = 1'b0;
      #12;
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_cnt", {30'd0, no_space_cnt}, 32'd0);
      rst = 1'b1;

      // 1: fill then drain in order
      wr_en = 1'b1; wr_data = 8'h11; tick();
      chk("t1_not_empty", {31'd0, empty}, 32'd0);
      wr_data = 8'h22; tick();
      wr_data = 8'h33; tick();
      wr_data = 8'h44; tick();
      wr_en = 1'b0;
      chk("t1_full", {31'd0, full}, 32'd1);
      chk("t1_err", {31'd0, no_space_err}, 32'd0);
      rd_en = 1'b1;
      tick(); chk("t1_rv", {31'd0, rd_valid}, 32'd1); chk("t1_rd0", {24'd0, rd_data}, 32'h11);
      tick(); chk("t1_rd1", {24'd0, rd_data}, 32'h22);
      tick(); chk("t1_rd2", {24'd0, rd_data}, 32'h33);
      tick(); chk("t1_rd3", {24'd0, rd_data}, 32'h44);
      rd_en = 1'b0;
      chk("t1_empty", {31'd0, empty}, 32'd1);
      tick();
      chk("t1_rv_off", {31'd0, rd_valid}, 32'd0);
      chk("t1_rd_hold", {24'd0, rd_data}, 32'h44);
      chk("t1_err_end", {31'd0, no_space_err}, 32'd0);

      // 2: refill, then 3 consecutive rejected writes form one episode
      wr_en = 1'b1;
      wr_data = 8'hA1; tick();
      wr_data = 8'hA2; tick();
      wr_data = 8'hA3; tick();
      wr_data = 8'hA4; tick();
      chk("t2_full", {31'd0, full}, 32'd1);
      chk("t2_err_pre", {31'd0, no_space_err}, 32'd0);
      wr_data = 8'hEE;
      tick(); chk("t2_err1", {31'd0, no_space_err}, 32'd1); chk("t2_inc1", {31'd0, no_space_ctr_incr}, 32'd0);
      tick(); chk("t2_err2", {31'd0, no_space_err}, 32'd1); chk("t2_inc2", {31'd0, no_space_ctr_incr}, 32'd1);
      tick(); chk("t2_err3", {31'd0, no_space_err}, 32'd1); chk("t2_inc3", {31'd0, no_space_ctr_incr}, 32'd0);
      chk("t2_cnt", {30'd0, no_space_cnt}, 32'd1);
      wr_en = 1'b0;
      tick(); chk("t2_err4", {31'd0, no_space_err}, 32'd0); chk("t2_inc4", {31'd0, no_space_ctr_incr}, 32'd0);
      tick(); chk("t2_cnt_end", {30'd0, no_space_cnt}, 32'd1);

      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("clr_cnt", {30'd0, no_space_cnt}, 32'd0);

      // 3: two rejected writes separated by an idle cycle -> two episodes
      wr_en = 1'b1; tick();
      wr_en = 1'b0; tick(); chk("t3_inc_a", {31'd0, no_space_ctr_incr}, 32'd1);
      wr_en = 1'b1; tick(); chk("t3_err_b", {31'd0, no_space_err}, 32'd1);
      chk("t3_inc_gap", {31'd0, no_space_ctr_incr}, 32'd0);
      wr_en = 1'b0; tick(); chk("t3_inc_b", {31'd0, no_space_ctr_incr}, 32'd1);
      tick();
      chk("t3_cnt", {30'd0, no_space_cnt}, 32'd2);
      chk("t3_sat", {31'd0, cnt_sat}, 32'd0);

      // 4: full FIFO, simultaneous write+read: write rejected, read served
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("t4_rd", {24'd0, rd_data}, 32'hA1);
      chk("t4_rv", {31'd0, rd_valid}, 32'd1);
      chk("t4_err", {31'd0, no_space_err}, 32'd1);
      chk("t4_not_full", {31'd0, full}, 32'd0);
      tick(); chk("t4_inc", {31'd0, no_space_ctr_incr}, 32'd1);
      tick(); chk("t4_cnt", {30'd0, no_space_cnt}, 32'd3); chk("t4_sat", {31'd0, cnt_sat}, 32'd1);
      rd_en = 1'b1;
      tick(); chk("t4_rd1", {24'd0, rd_data}, 32'hA2);
      tick(); chk("t4_rd2", {24'd0, rd_data}, 32'hA3);
      tick(); chk("t4_rd3", {24'd0, rd_data}, 32'hA4);
      rd_en = 1'b0;
      chk("t4_empty", {31'd0, empty}, 32'd1);

      // 5: saturation over 5 episodes, then clear coincident with incr
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("t5_clr", {30'd0, no_space_cnt}, 32'd0);
      wr_en = 1'b1;
      wr_data = 8'hB1; tick();
      wr_data = 8'hB2; tick();
      wr_data = 8'hB3; tick();
      wr_data = 8'hB4; tick();
      wr_en = 1'b0;
      tick();
      episode(2'd1, 1'b0);
      episode(2'd2, 1'b0);
      episode(2'd3, 1'b1);
      episode(2'd3, 1'b1);
      episode(2'd3, 1'b1);
      wr_en = 1'b1; tick();
      wr_en = 1'b0; tick();
      chk("t5_inc_clr", {31'd0, no_space_ctr_incr}, 32'd1);
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("t5_cnt_clr", {30'd0, no_space_cnt}, 32'd0);
      chk("t5_sat_clr", {31'd0, cnt_sat}, 32'd0);
      tick();
      chk("t5_cnt_lost", {30'd0, no_space_cnt}, 32'd0);

      // 6: async reset mid-episode with count nonzero
      wr_en = 1'b1;
      tick(); tick(); tick();
      chk("t6_err", {31'd0, no_space_err}, 32'd1);
      chk("t6_cnt", {30'd0, no_space_cnt}, 32'd1);
      wr_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("t6_err_rst", {31'd0, no_space_err}, 32'd0);
      chk("t6_inc_rst", {31'd0, no_space_ctr_incr}, 32'd0);
      chk("t6_cnt_rst", {30'd0, no_space_cnt}, 32'd0);
      chk("t6_sat_rst", {31'd0, cnt_sat}, 32'd0);
      chk("t6_full_rst", {31'd0, full}, 32'd0);
      chk("t6_empty_rst", {31'd0, empty}, 32'd1);
      chk("t6_rd_rst", {24'd0, rd_data}, 32'h00);
      #3 rst = 1'b1;
      tick(); chk("t6_inc_a", {31'd0, no_space_ctr_incr}, 32'd0);
      tick(); chk("t6_inc_b", {31'd0, no_space_ctr_incr}, 32'd0);
      chk("t6_err_after", {31'd0, no_space_err}, 32'd0);
      chk("t6_cnt_after", {30'd0, no_space_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_no_space_tracker.md
Name: fifo_no_space_tracker

Overview:
- Synchronous single-clock FIFO whose write side detects writes attempted while the FIFO is full.
- Drives `no_space_err` and a one-cycle `no_space_ctr_incr` pulse per error episode.
- Keeps a saturating error counter that software can clear.
- Sits in front of buffer consumers. It is the producer of the `no_space_err` / `no_space_ctr_incr` pair that the bench-side protocol assertions check.

Parameters:
- DATA_W, 8, data width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, error counter width in bits

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_data  out  DATA_W  read data, registered
- rd_valid  out  1  rd_data valid this cycle
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- no_space_err  out  1  previous cycle had a write rejected because the FIFO was full
- no_space_ctr_incr  out  1  one-cycle pulse, one per error episode
- no_space_cnt  out  CNT_W  saturating count of error episodes
- cnt_sat  out  1  no_space_cnt at all-ones
- cnt_clr  in  1  synchronous counter clear

Behaviour:
- Reset (rst=0, async, any time including mid-operation):
  - Pointers and occupancy go to 0, so empty=1 and full=0.
  - All other outputs go to 0: rd_data, rd_valid, no_space_err, no_space_ctr_incr, no_space_cnt, cnt_sat.
  - Stored data is discarded.
- Occupancy: a (log2(DEPTH)+1)-bit count.
  - full = (count==DEPTH); empty = (count==0).
  - Both are combinational from registered state.
- Write acceptance: accept = wr_en & ~full.
  - full is sampled before the edge.
  - A simultaneous rd_en does not make room for the same-cycle write.
  - Accepted data goes to mem[wr_ptr], and wr_ptr increments modulo DEPTH (wraps from DEPTH-1 to 0).
- Read: rd_ok = rd_en & ~empty.
  - On rd_ok, rd_data <= mem[rd_ptr], rd_valid <= 1, and rd_ptr wraps modulo DEPTH.
  - Otherwise rd_valid <= 0 and rd_data holds its value.
  - Read latency is 1 cycle.
  - Read on empty is ignored and raises no error.
- Occupancy update:
  - Accept and rd_ok in the same cycle: count unchanged.
  - Accept only: count +1.
  - rd_ok only: count −1.
- Error register: no_space_err <= wr_en & full.
  - It is high for every cycle following a rejected write.
  - Back-to-back rejected writes keep it continuously high; together they form one episode.
- Increment pulse: no_space_ctr_incr <= no_space_err & ~err_d, where err_d is no_space_err delayed by one cycle.
  - The pulse rises exactly one cycle after no_space_err rises.
  - It is high for exactly one cycle per episode, regardless of episode length.
  - A gap of ≥1 cycle with no_space_err=0 starts a new episode.
- Counter: on no_space_ctr_incr=1, no_space_cnt increments unless it is all-ones, in which case it holds.
  - cnt_sat = (no_space_cnt == all-ones), registered alongside the count.
  - cnt_clr=1 sets no_space_cnt=0 next edge.
  - cnt_clr has priority over a coincident increment; that increment is lost.
- FIFO contents are never modified by a rejected write.

Test Plan:
1. DEPTH=4. After reset, write 0x11,0x22,0x33,0x44 on 4 consecutive cycles, then read 4.
   → full=1 after the 4th write. rd_data = 0x11,0x22,0x33,0x44, each one cycle after its rd_en. empty=1 at the end. no_space_err stays 0.
2. With the FIFO full, hold wr_en=1 for 3 cycles.
   → no_space_err is high for 3 cycles, starting the cycle after the first rejected write.
   → no_space_ctr_incr is high for exactly 1 cycle, one cycle after no_space_err rises.
   → no_space_cnt goes 0→1. FIFO contents are unchanged.
3. Full FIFO; two rejected writes separated by one idle cycle.
   → Two separate incr pulses; no_space_cnt=2.
4. Full FIFO; wr_en=1 and rd_en=1 in the same cycle.
   → The write is rejected and no_space_err=1 next cycle. The read returns the oldest entry and count drops to 3.
5. CNT_W=2: produce 5 separate episodes.
   → no_space_cnt goes 1,2,3,3,3 and cnt_sat=1 from the 3rd episode onward.
   → Then assert cnt_clr in the same cycle as an incr pulse: no_space_cnt=0 and cnt_sat=0.
6. Assert rst=0 mid-episode, between the clock edges where no_space_err=1.
   → All outputs go to 0 immediately without waiting for a clock edge. No incr pulse appears after reset is released.
